// File: rtl/tilt_light_alarm_driver_if.sv
// Level-word input, buzzer drive and alarm status bundle for tilt_light_alarm_driver.
// The master drives the samples and controls; the slave drives buzzer and alarm_active.
interface tilt_light_alarm_driver_if;
    logic        sample_valid;
    logic [15:0] selected_data;
    logic        select;
    logic        mute;
    logic        ack;
    logic        buzzer;
    logic        alarm_active;

    modport master (
        output sample_valid, selected_data, select, mute, ack,
        input  buzzer, alarm_active
    );

    modport slave (
        input  sample_valid, selected_data, select, mute, ack,
        output buzzer, alarm_active
    );
endinterface

// File: rtl/tilt_light_alarm_driver.sv
// Qualifies over-threshold tilt/light samples and drives a gated square-wave beep; alarm_active 1 cycle after the qualifying strobe.
// No backpressure: every strobe is accepted. ALARM_LATCH_EN holds the alarm until an ack pulse.
module tilt_light_alarm_driver #(
    parameter int unsigned TONE_HALF = 12500,
    parameter int unsigned BEEP_ON   = 12500000,
    parameter int unsigned BEEP_OFF  = 12500000,
    parameter int unsigned ARM_COUNT = 3,
    parameter int unsigned GS_THRESH = 2,
    parameter int unsigned LS_THRESH = 5
) (
    input logic                      clk,
    input logic                      reset,
    tilt_light_alarm_driver_if.slave bus
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARMING    = 2'd1;
    localparam logic [1:0] ST_ALARM_ON  = 2'd2;
    localparam logic [1:0] ST_ALARM_OFF = 2'd3;

    localparam int unsigned WIN_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int WW = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          clear_pending;
    logic [TW-1:0] tone_cnt;
    logic [WW-1:0] win_cnt;
    logic          tone;
    logic          sel_q;

    logic [7:0] level;
    logic [7:0] mag;
    logic       over;
    logic       switch_src;
    logic       strobe;
    logic       in_alarm;
    logic       unused_bits;

    // Two's-complement magnitude kept 8 bits wide so that -128 reads as 128.
    assign level       = bus.selected_data[7:0];
    assign mag         = level[7] ? (~level + 8'd1) : level;
    assign over        = bus.select ? (32'(level) >= LS_THRESH) : (32'(mag) >= GS_THRESH);
    assign switch_src  = (bus.select != sel_q);
    assign strobe      = bus.sample_valid & ~switch_src;
    assign in_alarm    = state[1];
    assign unused_bits = ^{bus.selected_data[15:8], bus.ack};

    assign bus.buzzer       = tone & ~bus.mute;
    assign bus.alarm_active = in_alarm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= 4'd0;
            clear_pending <= 1'b0;
            tone_cnt      <= '0;
            win_cnt       <= '0;
            tone          <= 1'b0;
            sel_q         <= 1'b0;
        end else begin
            sel_q <= bus.select;
            if (switch_src
`ifdef ALARM_LATCH_EN
                || (bus.ack && in_alarm)
`endif
            ) begin
                state         <= ST_IDLE;
                cnt           <= 4'd0;
                clear_pending <= 1'b0;
                tone_cnt      <= '0;
                win_cnt       <= '0;
                tone          <= 1'b0;
            end else begin
`ifndef ALARM_LATCH_EN
                if (in_alarm && strobe)
                    clear_pending <= ~over;
`endif
                case (state)
                    ST_IDLE: begin
                        if (strobe && over) begin
                            if (ARM_COUNT <= 1) begin
                                state    <= ST_ALARM_ON;
                                cnt      <= 4'd0;
                                tone_cnt <= '0;
                                win_cnt  <= '0;
                                tone     <= 1'b0;
                            end else begin
                                state <= ST_ARMING;
                                cnt   <= 4'd1;
                            end
                        end
                    end
                    ST_ARMING: begin
                        if (strobe) begin
                            if (!over) begin
                                state <= ST_IDLE;
                                cnt   <= 4'd0;
                            end else if (cnt == 4'(ARM_COUNT - 1)) begin
                                state         <= ST_ALARM_ON;
                                cnt           <= 4'd0;
                                clear_pending <= 1'b0;
                                tone_cnt      <= '0;
                                win_cnt       <= '0;
                                tone          <= 1'b0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                    ST_ALARM_ON: begin
                        if (tone_cnt == TW'(TONE_HALF - 1)) begin
                            tone_cnt <= '0;
                            tone     <= ~tone;
                        end else begin
                            tone_cnt <= tone_cnt + 1'b1;
                        end
                        if (win_cnt == WW'(BEEP_ON - 1)) begin
                            state    <= ST_ALARM_OFF;
                            win_cnt  <= '0;
                            tone_cnt <= '0;
                            tone     <= 1'b0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                    default: begin
                        // Clear is only honoured here, so a beep window always runs to completion.
                        if (win_cnt == WW'(BEEP_OFF - 1)) begin
                            win_cnt  <= '0;
                            tone_cnt <= '0;
                            tone     <= 1'b0;
                            if (clear_pending) begin
                                state         <= ST_IDLE;
                                clear_pending <= 1'b0;
                            end else begin
                                state <= ST_ALARM_ON;
                            end
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tilt_light_alarm_driver.sv
// Self-checking bench for tilt_light_alarm_driver (TONE_HALF=4, BEEP_ON=32, BEEP_OFF=32, ARM_COUNT=3).
module tb_tilt_light_alarm_driver;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tilt_light_alarm_driver_if bus();

    tilt_light_alarm_driver #(
        .TONE_HALF(4), .BEEP_ON(32), .BEEP_OFF(32),
        .ARM_COUNT(3), .GS_THRESH(2), .LS_THRESH(5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        sv;
        logic        sel;
        logic [15:0] data;
        logic        exp_alarm;
        logic        exp_buz;
    } vec_t;

    typedef struct {
        logic alarm;
        logic buz;
        int   tag;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[19];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_out(input logic ea, input logic eb, input int tag);
        exp_t e;
        e.alarm = ea;
        e.buz   = eb;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: no expectation queued, got alarm_active=%b buzzer=%b",
                     bus.alarm_active, bus.buzzer);
        end else begin
            e = sb.pop_front();
            if ({bus.alarm_active, bus.buzzer} !== {e.alarm, e.buz}) begin
                n_bad++;
                $display("FAIL step %0d: alarm_active=%b buzzer=%b, expected alarm_active=%b buzzer=%b",
                         e.tag, bus.alarm_active, bus.buzzer, e.alarm, e.buz);
            end
        end
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic step(input logic sv, input logic sel, input logic mt, input logic ak,
                        input logic [15:0] d, input logic ea, input logic eb, input int tag);
        @(negedge clk);
        bus.sample_valid  = sv;
        bus.select        = sel;
        bus.mute          = mt;
        bus.ack           = ak;
        bus.selected_data = d;
        expect_out(ea, eb, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        logic        sv, mt, ea, eb;
        logic [15:0] d;
        int          phase;

        vecs[0]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h00FE, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h00FE, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h00FE, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 16'h0005, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h0005, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'h0004, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 16'h0005, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 16'hFF05, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 16'h0005, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 16'h0080, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 16'h0080, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 16'h007F, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};

        reset             = 1'b1;
        bus.sample_valid  = 1'b0;
        bus.select        = 1'b0;
        bus.mute          = 1'b0;
        bus.ack           = 1'b0;
        bus.selected_data = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        expect_out(1'b0, 1'b0, 0);
        check_out();
        @(negedge clk);
        reset = 1'b0;

        // Arming, thresholds, broken runs and source switches.
        for (int i = 0; i < 19; i++)
            step(vecs[i].sv, vecs[i].sel, 1'b0, 1'b0, vecs[i].data,
                 vecs[i].exp_alarm, vecs[i].exp_buz, 100 + i);

        // Light-sensor alarm: tone/window timing, mute, clear then re-over, final clear.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 900);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 901);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 902);
        for (int k = 1; k <= 135; k++) begin
            sv = 1'b0;
            d  = 16'h0000;
            mt = (k >= 10 && k <= 17);
            if (k == 40 || k == 70) sv = 1'b1;
            if (k == 45) begin
                sv = 1'b1;
                d  = 16'h0007;
            end
`ifdef ALARM_LATCH_EN
            ea = 1'b1;
`else
            ea = (k < 128);
`endif
            phase = k % 64;
            eb = ea && (phase < 32) && (((phase / 4) % 2) == 1) && !mt;
            step(sv, 1'b1, mt, 1'b0, d, ea, eb, 1000 + k);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1136);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1137);

        // Asynchronous reset while the buzzer is high.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 2000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 2001);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 2002);
        for (int k = 1; k <= 5; k++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, (k >= 4), 2002 + k);
        #1;
        reset = 1'b1;
        #1;
        expect_out(1'b0, 1'b0, 3000);
        check_out();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
